// File: rtl/dbn_mc_pkg.sv
// ---- dbn_mc_pkg : default geometry shared by the debouncer slice | rev 1.0 ----
`default_nettype none

package dbn_mc_pkg;
  localparam int DBN_CH_NUM     = 4;
  localparam int DBN_SYNC_DEPTH = 2;
  localparam int DBN_CNT_WIDTH  = 8;
  localparam int DBN_HOLD_WIDTH = 16;
endpackage

`default_nettype wire

// File: rtl/dbn_mc_ch.sv
// ---- dbn_ch : one debounce channel (settle counter, level flop, edges, hold) | rev 1.0 ----
`default_nettype none

module dbn_ch import dbn_mc_pkg::*; #(
  parameter int   CNT_WIDTH  = DBN_CNT_WIDTH,
  parameter int   HOLD_WIDTH = DBN_HOLD_WIDTH,
  parameter logic RST_VAL    = 1'b0,
  parameter logic ACTIVE_LVL = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic [CNT_WIDTH-1:0]  dbn_thr_i,
  input  logic [HOLD_WIDTH-1:0] hold_thr_i,
  input  logic                  sync_d_i,
  input  logic                  sync_q_i,
  output logic                  dbn_o,
  output logic                  pe_o,
  output logic                  ne_o,
  output logic                  hold_o,
  output logic                  evt_o
);

  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [HOLD_WIDTH-1:0] hcnt_q, hcnt_d;
  logic dbn_q, dbn_d, pe_q, pe_d, ne_q, ne_d, hold_q, hold_d;
  logic stable, pressed;

  always_comb begin
    // gating stable with en_i keeps the level frozen while disabled, even for a zero threshold
    stable = en_i && (cnt_q >= dbn_thr_i);
    cnt_d  = cnt_q;
    if (!en_i || (sync_d_i != sync_q_i)) cnt_d = '0;
    else if (cnt_q < dbn_thr_i)          cnt_d = cnt_q + CNT_WIDTH'(1);

    dbn_d = stable ? sync_q_i : dbn_q;
    pe_d  = stable && !dbn_q && sync_q_i;
    ne_d  = stable && dbn_q && !sync_q_i;

    pressed = en_i && (dbn_q == ACTIVE_LVL);
    hcnt_d  = hcnt_q;
    hold_d  = 1'b0;
    if (!pressed) begin
      hcnt_d = '0;
    end else if (hcnt_q < hold_thr_i) begin
      hcnt_d = hcnt_q + HOLD_WIDTH'(1);
      hold_d = (hcnt_d == hold_thr_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      hcnt_q <= '0;
      dbn_q  <= RST_VAL;
      pe_q   <= 1'b0;
      ne_q   <= 1'b0;
      hold_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      hcnt_q <= hcnt_d;
      dbn_q  <= dbn_d;
      pe_q   <= pe_d;
      ne_q   <= ne_d;
      hold_q <= hold_d;
    end
  end

  assign dbn_o  = dbn_q;
  assign pe_o   = pe_q;
  assign ne_o   = ne_q;
  assign hold_o = hold_q;
  assign evt_o  = pe_d | ne_d;

endmodule

`default_nettype wire

// File: rtl/dbn_mc_sync.sv
// ---- dbn_mc_sync : multi-bit flop-chain synchronizer | rev 1.0 ----
`default_nettype none

module dbn_mc_sync #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = d_i;
    for (int k = 1; k < DEPTH; k++) stage_d[k] = stage_q[k-1];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < DEPTH; k++) stage_q[k] <= RST_VAL;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/dbn_mc.sv
// ---- dbn_mc : multi-channel debouncer with edge and long-press pulses | rev 1.0 ----
`default_nettype none

module dbn_mc import dbn_mc_pkg::*; #(
  parameter int                CH_NUM     = DBN_CH_NUM,
  parameter int                SYNC_DEPTH = DBN_SYNC_DEPTH,
  parameter int                CNT_WIDTH  = DBN_CNT_WIDTH,
  parameter int                HOLD_WIDTH = DBN_HOLD_WIDTH,
  parameter logic [CH_NUM-1:0] RST_VAL    = '0,
  parameter logic [CH_NUM-1:0] ACTIVE_LVL = '1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic [CNT_WIDTH-1:0]  dbn_thr_i,
  input  logic [HOLD_WIDTH-1:0] hold_thr_i,
  input  logic [CH_NUM-1:0]     sig_i,
  output logic [CH_NUM-1:0]     sig_dbn_o,
  output logic [CH_NUM-1:0]     sig_pe_o,
  output logic [CH_NUM-1:0]     sig_ne_o,
  output logic [CH_NUM-1:0]     sig_hold_o,
  output logic                  sig_ae_o
);

  logic [CH_NUM-1:0] sync_d, sync_q, evt;
  logic              ae_d, ae_q;

  dbn_mc_sync #(
    .WIDTH  (CH_NUM),
    .DEPTH  (SYNC_DEPTH),
    .RST_VAL(RST_VAL)
  ) u_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (sig_i),
    .q_o   (sync_d)
  );

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    dbn_ch #(
      .CNT_WIDTH (CNT_WIDTH),
      .HOLD_WIDTH(HOLD_WIDTH),
      .RST_VAL   (RST_VAL[i]),
      .ACTIVE_LVL(ACTIVE_LVL[i])
    ) u_ch (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .en_i      (en_i),
      .dbn_thr_i (dbn_thr_i),
      .hold_thr_i(hold_thr_i),
      .sync_d_i  (sync_d[i]),
      .sync_q_i  (sync_q[i]),
      .dbn_o     (sig_dbn_o[i]),
      .pe_o      (sig_pe_o[i]),
      .ne_o      (sig_ne_o[i]),
      .hold_o    (sig_hold_o[i]),
      .evt_o     (evt[i])
    );
  end

  always_comb begin
    ae_d = |evt;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= RST_VAL;
      ae_q   <= 1'b0;
    end else begin
      sync_q <= sync_d;
      ae_q   <= ae_d;
    end
  end

  assign sig_ae_o = ae_q;

endmodule

`default_nettype wire

// File: tb/tb_dbn_mc.sv
// ---- tb_dbn_mc : self-checking bench for dbn_mc | rev 1.0 ----
`default_nettype none

module tb_dbn_mc;

  localparam int D    = 2;
  localparam int NRND = 2400;
  localparam int NMAX = 64 + NRND;

  logic        clk, rst_ni, en_i;
  logic [7:0]  dbn_thr_i;
  logic [15:0] hold_thr_i;
  logic [3:0]  sig_i, sig_dbn_o, sig_pe_o, sig_ne_o, sig_hold_o;
  logic        sig_ae_o;

  int total = 0;
  int bad   = 0;

  dbn_mc dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .en_i      (en_i),
    .dbn_thr_i (dbn_thr_i),
    .hold_thr_i(hold_thr_i),
    .sig_i     (sig_i),
    .sig_dbn_o (sig_dbn_o),
    .sig_pe_o  (sig_pe_o),
    .sig_ne_o  (sig_ne_o),
    .sig_hold_o(sig_hold_o),
    .sig_ae_o  (sig_ae_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    int ch;
    int thr;
    int exp_edge;
  } lat_vec_t;

  lat_vec_t lat_tab [5];

  // reference history, indexed by clock edge number
  logic [3:0] samp  [NMAX];
  logic       en_h  [NMAX];
  logic [3:0] dbn_h [NMAX];
  logic [3:0] ok_h  [NMAX];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_ni     = 1'b0;
    sig_i      = '0;
    en_i       = 1'b1;
    hold_thr_i = '0;
    tick();
    tick();
    rst_ni = 1'b1;
  endtask

  // a channel settles when the last t+1 synchronized samples agree and enable covered the window
  function automatic logic stable_at(int n, int ch, int t);
    for (int k = 0; k <= t; k++) begin
      if (!en_h[n-k]) return 1'b0;
      if (samp[n-1-D-k][ch] != samp[n-1-D][ch]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // hold fires on the h-th consecutive enabled-and-active edge
  function automatic logic hold_at(int n, int ch, int h);
    if (h == 0) return 1'b0;
    for (int k = 0; k < h; k++) if (!ok_h[n-k][ch]) return 1'b0;
    return !ok_h[n-h][ch];
  endfunction

  initial begin
    int got, cnt_a, cnt_b, cnt_c, rise_k, hold_k, first;
    int cur_t, cur_h, tgl;
    logic prev;
    logic [3:0] e_pe, e_ne, e_hold;
    logic st, qv;

    lat_tab[0] = '{0, 3, 7};
    lat_tab[1] = '{1, 0, 4};
    lat_tab[2] = '{2, 1, 5};
    lat_tab[3] = '{3, 5, 9};
    lat_tab[4] = '{0, 12, 16};

    rst_ni = 1'b0; sig_i = '0; en_i = 1'b1; dbn_thr_i = 8'd3; hold_thr_i = '0;
    #12;
    chk("reset dbn", sig_dbn_o, 4'h0);
    chk("reset pulses", {sig_pe_o, sig_ne_o, sig_hold_o, sig_ae_o}, 0);

    // press latency table
    for (int r = 0; r < 5; r++) begin
      do_reset();
      dbn_thr_i = 8'(lat_tab[r].thr);
      repeat (5) tick();
      sig_i[lat_tab[r].ch] = 1'b1;
      got = 0;
      for (int k = 1; k <= 40; k++) begin
        tick();
        if (sig_dbn_o[lat_tab[r].ch]) begin got = k; break; end
      end
      chk($sformatf("lat edge row%0d", r), got, lat_tab[r].exp_edge);
      chk($sformatf("lat pe row%0d", r), sig_pe_o, 32'd1 << lat_tab[r].ch);
      chk($sformatf("lat ae row%0d", r), sig_ae_o, 1);
      tick();
      chk($sformatf("lat pe width row%0d", r), {sig_pe_o, sig_ae_o}, 0);
    end

    // asynchronous reset in the middle of a count
    do_reset();
    dbn_thr_i = 8'd2;
    sig_i = 4'b1010;
    repeat (10) tick();
    chk("pre-reset dbn", sig_dbn_o, 4'b1010);
    dbn_thr_i = 8'd50;
    sig_i = 4'b0101;
    repeat (10) tick();
    #3 rst_ni = 1'b0;
    #1;
    chk("async reset dbn", sig_dbn_o, 4'h0);
    chk("async reset pulses", {sig_pe_o, sig_ne_o, sig_hold_o, sig_ae_o}, 0);
    #1 rst_ni = 1'b1;
    cnt_a = 0;
    repeat (20) begin
      tick();
      if ({sig_pe_o, sig_ne_o, sig_hold_o, sig_ae_o} != 0 || sig_dbn_o != 0) cnt_a++;
    end
    chk("post-reset quiet", cnt_a, 0);

    // bouncing ch1
    do_reset();
    dbn_thr_i = 8'd5;
    repeat (5) tick();
    cnt_a = 0; cnt_b = 0; cnt_c = 0; prev = sig_dbn_o[1];
    for (int i = 0; i < 50; i++) begin
      sig_i[1] = (i < 20) ? (((i / 2) % 2) == 0) : 1'b1;
      tick();
      cnt_a += int'(sig_pe_o[1]);
      cnt_b += int'(sig_ne_o[1]);
      if (sig_dbn_o[1] != prev) cnt_c++;
      prev = sig_dbn_o[1];
    end
    chk("bounce pe count", cnt_a, 1);
    chk("bounce ne count", cnt_b, 0);
    chk("bounce dbn changes", cnt_c, 1);

    // simultaneous fall on ch0 and rise on ch2
    do_reset();
    dbn_thr_i = 8'd3;
    sig_i = 4'b0001;
    repeat (12) tick();
    chk("simul pre dbn", sig_dbn_o, 4'b0001);
    sig_i = 4'b0100;
    cnt_a = 0; cnt_b = 0; first = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      cnt_a += int'(sig_ae_o);
      if ((sig_pe_o | sig_ne_o) != 0) begin
        cnt_b++;
        if (first == 0) begin
          first = 1;
          chk("simul ne", sig_ne_o, 4'b0001);
          chk("simul pe", sig_pe_o, 4'b0100);
          chk("simul ae", sig_ae_o, 1);
        end
      end
    end
    chk("simul ae cycles", cnt_a, 1);
    chk("simul edge cycles", cnt_b, 1);
    chk("simul post dbn", sig_dbn_o, 4'b0100);

    // long press on ch3
    do_reset();
    dbn_thr_i = 8'd2; hold_thr_i = 16'd10;
    repeat (5) tick();
    sig_i = 4'b1000;
    rise_k = 0; hold_k = 0; cnt_a = 0;
    for (int k = 1; k <= 50; k++) begin
      tick();
      if (sig_dbn_o[3] && rise_k == 0) rise_k = k;
      if (sig_hold_o[3]) begin cnt_a++; hold_k = k; end
    end
    chk("hold delay", hold_k - rise_k, 10);
    chk("hold count", cnt_a, 1);
    sig_i = 4'b0000;
    repeat (10) tick();
    cnt_a = 0; cnt_b = 0;
    sig_i = 4'b1000;
    for (int k = 0; k < 38; k++) begin
      if (k == 8) sig_i = 4'b0000;
      tick();
      cnt_a += int'(sig_hold_o[3]);
      cnt_b += int'(sig_pe_o[3]);
    end
    chk("short press pe", cnt_b, 1);
    chk("short press hold", cnt_a, 0);
    hold_thr_i = 16'd0;
    sig_i = 4'b1000;
    cnt_a = 0;
    repeat (40) begin tick(); cnt_a += int'(sig_hold_o[3]); end
    chk("hold disabled count", cnt_a, 0);
    chk("hold disabled dbn", sig_dbn_o[3], 1);

    // enable dropped mid-count
    do_reset();
    dbn_thr_i = 8'd20;
    repeat (5) tick();
    sig_i[0] = 1'b1;
    repeat (10) tick();
    en_i = 1'b0;
    cnt_a = 0;
    repeat (30) begin
      tick();
      if (sig_dbn_o != 0 || {sig_pe_o, sig_ne_o, sig_hold_o, sig_ae_o} != 0) cnt_a++;
    end
    chk("disabled activity", cnt_a, 0);
    en_i = 1'b1;
    got = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (sig_dbn_o[0]) begin got = k; break; end
    end
    chk("re-enable latency", got, 21);

    // lowering the threshold under a running count
    do_reset();
    dbn_thr_i = 8'd200;
    repeat (5) tick();
    sig_i[0] = 1'b1;
    repeat (50) tick();
    chk("thr200 dbn", sig_dbn_o[0], 0);
    dbn_thr_i = 8'd2;
    tick();
    chk("thr drop dbn", sig_dbn_o[0], 1);
    chk("thr drop pe", sig_pe_o[0], 1);

    // randomized run against the history-window reference
    do_reset();
    for (int i = 0; i < 64; i++) begin
      samp[i] = '0; en_h[i] = 1'b0; dbn_h[i] = '0; ok_h[i] = '0;
    end
    cur_t = 0; cur_h = 0; tgl = 4;
    for (int n = 64; n < NMAX; n++) begin
      if (((n - 64) % 300) == 0) begin
        cur_t = int'($urandom_range(0, 7));
        cur_h = int'($urandom_range(0, 12));
        case ($urandom_range(0, 2))
          0:       tgl = 4;
          1:       tgl = 16;
          default: tgl = 40;
        endcase
        dbn_thr_i  = 8'(cur_t);
        hold_thr_i = 16'(cur_h);
        en_i = 1'b0;
      end else begin
        en_i = ($urandom_range(0, 59) != 0);
      end
      for (int ch = 0; ch < 4; ch++)
        if ($urandom_range(0, tgl - 1) == 0) sig_i[ch] = ~sig_i[ch];
      samp[n] = sig_i;
      en_h[n] = en_i;
      for (int ch = 0; ch < 4; ch++) begin
        st = stable_at(n, ch, cur_t);
        qv = samp[n-1-D][ch];
        e_pe[ch]     = st && !dbn_h[n-1][ch] && qv;
        e_ne[ch]     = st && dbn_h[n-1][ch] && !qv;
        dbn_h[n][ch] = st ? qv : dbn_h[n-1][ch];
        ok_h[n][ch]  = en_h[n] && dbn_h[n-1][ch];
        e_hold[ch]   = hold_at(n, ch, cur_h);
      end
      tick();
      chk($sformatf("rand edge %0d", n),
          {15'd0, sig_dbn_o, sig_pe_o, sig_ne_o, sig_hold_o, sig_ae_o},
          {15'd0, dbn_h[n], e_pe, e_ne, e_hold, |(e_pe | e_ne)});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
